// File: rtl/uart_core_rx_if.sv
// Receiver-to-register-side handshake: enable in, completed character and status out.
// The register/FIFO logic is the master; the receive core is the slave.
interface uart_core_rx_if;
  logic       en;
  logic       busy;
  logic       ack;
  logic [7:0] data;
  logic       err_check;
  logic       err_frame;

  modport master (output en, input busy, ack, data, err_check, err_frame);
  modport slave  (input en, output busy, ack, data, err_check, err_frame);
endinterface

// File: rtl/uart_core_rx.sv
// UART receive core: 2-flop synchroniser, 8x oversampling tick generator and a frame FSM
// that majority-votes each bit and reports the character with a one-cycle ack.
module uart_core_rx #(
  parameter int CLK_FREQ       = 100,
  parameter int BAUD_DIV_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]                data_type,
  input  logic [1:0]                stop_type,
  input  logic                      check_en,
  input  logic [1:0]                check_type,
  input  logic                      rx,
  uart_core_rx_if.slave             host
);
  localparam int CLK_DIV = CLK_FREQ / 10;
  localparam int CNT_W   = BAUD_DIV_WIDTH + $clog2(CLK_DIV) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_CHECK, S_STOP0, S_STOP1, S_WAITHI
  } state_t;

  state_t           state_r;
  logic             rx_meta_r, rx_s_r, rx_prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [2:0]       bit_cnt_r;
  logic             vote3_r, vote4_r;
  logic [7:0]       buf_r;
  logic             chk_err_r;
  logic             busy_r, ack_r, err_check_r, err_frame_r;
  logic [7:0]       data_r;

  logic [CNT_W-1:0] period_s, first_cnt_s;
  logic             tick_s, maj_s, sample_s, last_bit_s, start_s;

  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] kind);
    logic p;
    case (kind)
      2'b00:   p = ~^d;
      2'b01:   p = ^d;
      2'b10:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  assign host.busy      = busy_r;
  assign host.ack       = ack_r;
  assign host.data      = data_r;
  assign host.err_check = err_check_r;
  assign host.err_frame = err_frame_r;

  // Tick timing, bit vote and edge detection.
  always_comb begin
    period_s    = CNT_W'(CLK_DIV) * (CNT_W'(baud_div) + CNT_W'(1));
    // The detection cycle already counts as the first clock of the period.
    first_cnt_s = (period_s == CNT_W'(1)) ? '0 : CNT_W'(1);
    tick_s      = (cnt_r >= period_s - CNT_W'(1));
    maj_s       = (vote3_r & vote4_r) | (vote3_r & rx_s_r) | (vote4_r & rx_s_r);
    sample_s    = tick_s && (idx_r == 3'd5);
    last_bit_s  = (bit_cnt_r == (3'd7 - {1'b0, data_type}));
    start_s     = host.en && rx_prev_r && !rx_s_r;
  end

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
      rx_prev_r <= rx_s_r;
    end
  end

  // Frame FSM with tick generator, bit sampling and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      bit_cnt_r   <= 3'd0;
      vote3_r     <= 1'b0;
      vote4_r     <= 1'b0;
      buf_r       <= 8'h00;
      chk_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      ack_r       <= 1'b0;
      data_r      <= 8'h00;
      err_check_r <= 1'b0;
      err_frame_r <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      if (state_r == S_IDLE) begin
        idx_r <= 3'd0;
        if (start_s) begin
          state_r   <= S_START;
          busy_r    <= 1'b1;
          cnt_r     <= first_cnt_s;
          bit_cnt_r <= 3'd0;
          buf_r     <= 8'h00;
          chk_err_r <= 1'b0;
        end else begin
          cnt_r <= '0;
        end
      end else if (!host.en) begin
        state_r <= S_IDLE;
        busy_r  <= 1'b0;
        cnt_r   <= '0;
      end else begin
        if (tick_s) begin
          cnt_r <= '0;
          idx_r <= idx_r + 3'd1;
          if (idx_r == 3'd3) vote3_r <= rx_s_r;
          if (idx_r == 3'd4) vote4_r <= rx_s_r;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        case (state_r)
          S_START: begin
            if (sample_s && maj_s) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end else if (tick_s && (idx_r == 3'd7)) begin
              state_r <= S_DATA;
            end
          end
          S_DATA: begin
            if (sample_s) begin
              buf_r[bit_cnt_r] <= maj_s;
              if (last_bit_s) state_r <= check_en ? S_CHECK : S_STOP0;
              else            bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          S_CHECK: begin
            if (sample_s) begin
              chk_err_r <= (maj_s != parity_bit(buf_r, check_type));
              state_r   <= S_STOP0;
            end
          end
          S_STOP0: begin
            if (sample_s) begin
              if (!maj_s || (stop_type != 2'b10)) begin
                ack_r       <= 1'b1;
                data_r      <= buf_r;
                err_check_r <= chk_err_r;
                err_frame_r <= !maj_s;
                state_r     <= maj_s ? S_IDLE : S_WAITHI;
                busy_r      <= !maj_s;
              end else begin
                state_r <= S_STOP1;
              end
            end
          end
          S_STOP1: begin
            if (sample_s) begin
              ack_r       <= 1'b1;
              data_r      <= buf_r;
              err_check_r <= chk_err_r;
              err_frame_r <= !maj_s;
              state_r     <= maj_s ? S_IDLE : S_WAITHI;
              busy_r      <= !maj_s;
            end
          end
          // A break or stuck-low line must go high before another start is accepted.
          S_WAITHI: begin
            if (rx_s_r) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/uart_core_rx.md
# uart_core_rx

Receive half of the UART core: deserialises one asynchronous character from the `rx` line and presents it with a one-cycle acknowledge. It shares the companion transmitter's character-format controls (`baud_div`, `data_type`, `stop_type`, `check_en`, `check_type`) and uses the same timebase: 10 MHz prescale, then `baud_div` division, then 8 samples per bit. It sits between the UART pin and the UART register/FIFO logic.

## Interface
- `CLK_FREQ`, 100: main clock frequency in MHz; must be a multiple of 10. `CLK_DIV = CLK_FREQ/10`.
- `BAUD_DIV_WIDTH`, 8: width of `baud_div`.
- `clk`  in  1  main clock.
- `rst`  in  1  reset, synchronous, active-high.
- `baud_div`  in  BAUD_DIV_WIDTH  baud division; `baud_div = 10M/8/baudrate - 1`.
- `data_type`  in  2  data bits: 00=8, 01=7, 10=6, 11=5.
- `stop_type`  in  2  stop bits: 00=1, 01=1.5, 10=2, 11 treated as 00.
- `check_en`  in  1  parity bit present.
- `check_type`  in  2  parity type: 00=odd, 01=even, 10=mark, 11=space.
- `en`  in  1  receiver enable.
- `rx`  in  1  asynchronous serial input; idle high.
- `busy`  out  1  high while a frame is being received.
- `ack`  out  1  one-cycle pulse: a frame has completed.
- `data`  out  8  received character, LSB first on the line; unused upper bits are 0.
- `err_check`  out  1  parity mismatch on the frame flagged by `ack`.
- `err_frame`  out  1  first stop bit sampled low (or second stop bit, when stop_type=10).

## Operation
- **Synchroniser:** `rx` passes through 2 flops, giving `rx_s`. All decisions use `rx_s`.
- **Tick generator:** one sample tick every `CLK_DIV*(baud_div+1)` clocks. The generator is held cleared in S_IDLE and restarts on start-edge detection, so tick k falls k×that period after the edge. One bit period is 8 ticks, indexed 0..7. Each bit takes the majority vote of `rx_s` at ticks 3, 4 and 5; its value is final at tick 5.
- **States:** S_IDLE, S_START, S_DATA (bit counter 0..N-1), S_CHECK, S_STOP0, S_STOP1, S_WAITHI.
- **S_IDLE:** when `en`=1 and `rx_s` falls 1→0, go to S_START.
- **S_START:**
  - Majority=1 (glitch): return to S_IDLE, no `ack`.
  - Majority=0: go to S_DATA at the end of tick 7.
- **S_DATA:** shift bits into a buffer LSB first. After N = 8/7/6/5 bits, go to S_CHECK if `check_en`, else S_STOP0.
- **S_CHECK:** compute the expected parity over the N data bits:
  - odd: ~^data
  - even: ^data
  - mark: 1
  - space: 0
  - Set `err_check` if the sampled bit differs.
- **S_STOP0:**
  - Sampled 0: `err_frame` set, complete, then go to S_WAITHI.
  - stop_type=10: go to S_STOP1.
  - Otherwise: complete and go to S_IDLE. The extra half stop bit of 1.5 is not checked.
- **S_STOP1:** sample 0 sets `err_frame`. Complete, then go to S_IDLE (or S_WAITHI if `err_frame`).
- **S_WAITHI:** wait for `rx_s`=1, then go to S_IDLE. This prevents a break or stuck-low line from re-triggering.
- **Complete:** `data` (zero-extended), `err_check` and `err_frame` update in the same cycle `ack`=1. They hold until the next `ack`.
- **`en`:**
  - `en`=0 in any state other than S_IDLE aborts to S_IDLE with no `ack`. Outputs keep their previous values.
  - Format inputs must be stable while `busy`=1. Changing them mid-frame is undefined, but the block must still return to S_IDLE.

## Timing
- **Reset values:** `busy`=0, `ack`=0, `data`=0, `err_check`=0, `err_frame`=0; state S_IDLE; counters 0. A reset mid-frame discards the frame; no `ack`.
- **`busy`:** high from the cycle after the edge is detected until the cycle `ack` is high. It stays high through S_WAITHI.
- **`ack`:** exactly one clock wide. It is registered high one clock after the final stop sample tick (tick 5 of the last stop bit).
- **Latency, 8N1:** the final sample is tick 9×8+5 = 77 after the edge, so `ack` comes 78 tick periods after edge detection, plus 2 clocks of synchroniser delay.
- **Back-to-back frames:** after a 1-stop-bit frame returns to S_IDLE at tick 5 of the stop bit, a start edge arriving 3 ticks later is accepted.

## Test plan
All scenarios use CLK_FREQ=100, baud_div=0: tick every 10 clocks, bit time 80 clocks.
- **8N1, 0xA5:** one `ack`, `data`=0xA5, both errors 0. `ack` arrives 780±2 clocks after the start falling edge; `busy` stays high throughout.
- **7E1, 0x35:**
  - Correct parity bit 0: `data`=0x35, `err_check`=0.
  - Repeat with parity 1: `data`=0x35, `err_check`=1.
- **Start glitch:** `rx` low for 20 clocks only. Result: no `ack`, `busy` returns to 0 within 6 ticks, and a following valid 0x3C frame is received correctly.
- **5N2 with stop_type=10:**
  - Second stop bit low: `ack`, `err_frame`=1.
  - Then hold `rx` low 500 clocks: no new frame.
  - Then raise `rx` and send 0x1F: `data`=0x1F, `err_frame`=0.
- **Back-to-back 8N1, 0x00 then 0xFF with no idle gap:** two `ack` pulses, 800 clocks apart, with matching `data`.
- **Aborts:** `rst` pulsed at data bit 3, and separately `en` dropped at data bit 3. In both cases: no `ack`, `busy`=0 next cycle. After `rst`, all outputs are 0; after the `en` drop, outputs are unchanged.
